absorb_ctrl_576: RTL and testbench
==================================

Name: absorb_ctrl_576

Overview:
- Absorb-side controller for the 576-bit-rate (72-byte) Keccak hash path; the G function uses SHA3-512.
- Accepts a message as a stream of 64-bit words and packs 9 words into a 576-bit block.
- Applies domain-byte and final-bit padding to the last block, and inserts an extra padding-only block when the message fills a block exactly.
- Hands each block to the permutation core with a full/ack handshake. Sits between the message source and the f-permutation.

Parameters:
- PAD_BYTE, 8'h06, domain/pad byte written immediately after the last message byte (8'h1F for SHAKE use).
- WORDS, 9, 64-bit words per block; fixed for the 576-bit rate.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- in  in  64  message word; first message byte in in[63:56]
- in_valid  in  1  in holds a word
- in_ready  out  1  controller can accept a word this cycle
- is_last  in  1  qualifies the word as the last of the message
- byte_num  in  4  valid bytes in the last word, 0..8; values 9..15 treated as 8; ignored unless is_last
- out  out  576  block; byte j at out[575-8j -: 8]
- out_valid  out  1  block complete, held stable until acked
- out_last  out  1  out is the final block of the message
- f_ack  in  1  one-cycle pulse: permutation consumed out

Behaviour:
- Reset, asynchronous: state=FILL, word index k=0, out=0, out_valid=0, out_last=0, in_ready=1. A reset mid-block or mid-padding discards everything.
- Accept: a word is taken when in_valid && in_ready. It is written to word slot k, and k increments.
- State FILL (in_ready=1):
  - Non-last word with k<8: stay in FILL.
  - Non-last word with k=8: go to FULL next cycle, out_last=0.
  - Last word with m=byte_num: the message ends at byte p=8k+m.
    - Bytes p..71 of the written slot and of all later slots are zeroed.
    - If p<72: byte p = PAD_BYTE, byte 71 |= 8'h80; go to FULL with out_last=1. When p=71, byte 71 = PAD_BYTE|8'h80 (0x86 by default).
    - If p=72 (k=8, m=8): go to FULL with out_last=0 and a pending-pad flag set.
- State FULL: out_valid=1, in_ready=0, out held stable.
  - f_ack with out_last=1: go to FILL, clear k, out_valid=0 next cycle; ready for a new message.
  - f_ack, not last, no pending pad: go to FILL, clear k.
  - f_ack with pending pad: go to PAD.
- State PAD (1 cycle): out = byte 0 PAD_BYTE, bytes 1..70 zero, byte 71 8'h80. Go to FULL with out_last=1 and clear the pending-pad flag.
- Latency:
  - out_valid rises the cycle after the accepting edge of the 9th word or of the last word.
  - The padding-only block is valid 2 cycles after the f_ack of the full block.
- f_ack outside FULL is ignored.
- in_valid while in_ready=0 is ignored; no word is lost, the source holds it.
- Empty message: a last word with m=0 at k=0 gives block byte 0 = PAD_BYTE, byte 71 = 0x80.
- Throughput: at most one word per cycle. Output is registered; nothing combinational flows from in to out.

Optional Feature:
- Macro ABSORB576_BYTECNT_EN.
- When defined: adds output msg_bytes[15:0], the message bytes absorbed so far.
  - A non-last word adds 8; a last word adds byte_num after clamping.
  - Saturates at 16'hFFFF.
  - Cleared on reset and on the f_ack of the out_last block.
- When undefined: the port and counter are absent, and behaviour is otherwise identical.

Test Plan:
- 3-byte message: one word 64'h90ABCDEF11111111, is_last, byte_num=3 -> out = 576'h90ABCD06 followed by 67 zero bytes then 8'h80; out_valid=1, out_last=1 one cycle after accept.
- 9 full words of 64'h0123456789ABCDEF, last with byte_num=8:
  - First block = 9 copies, out_last=0.
  - After f_ack, a second block with byte 0 = 06, byte 71 = 80 and out_last=1 appears 2 cycles later.
- 71-byte message (9th word is_last, byte_num=7) -> byte 71 = 8'h86, single block, out_last=1.
- Backpressure: hold f_ack low for 10 cycles with in_valid=1 -> in_ready=0 and out stable throughout; after f_ack, the next word is accepted in the following FILL cycle.
- Reset asserted asynchronously after 4 words -> out_valid=0, k=0 immediately; a fresh 3-byte message then yields the same block as the first scenario.
- With ABSORB576_BYTECNT_EN: 20 words (2 full blocks) plus a last word with byte_num=5 -> msg_bytes=165 before the final f_ack, and 0 after it.

Source files
------------

// File: rtl/absorb_ctrl_576.sv
`default_nettype none
// ============================================================================
//  Module   : absorb_ctrl_576
//  Purpose  : Absorb-side controller for the 576-bit-rate (72-byte) Keccak
//             path. Packs nine 64-bit message words into one block, applies
//             domain-byte / final-bit padding to the last block, inserts an
//             extra padding-only block when the message fills a block
//             exactly, and hands blocks to the permutation via full/ack.
//  Options  : define ABSORB576_BYTECNT_EN to add the msg_bytes[15:0] output
//             (saturating count of message bytes absorbed so far).
//  Revision : 1.0  initial release
// ============================================================================
module absorb_ctrl_576 #(
    parameter logic [7:0] PAD_BYTE = 8'h06,
    parameter int         WORDS    = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [63:0]           in,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  is_last,
    input  logic [3:0]            byte_num,
    output logic [64*WORDS-1:0]   out,
    output logic                  out_valid,
    output logic                  out_last,
    input  logic                  f_ack
`ifdef ABSORB576_BYTECNT_EN
    ,
    output logic [15:0]           msg_bytes
`endif
);

    localparam int c_W     = 64 * WORDS;
    localparam int c_BYTES = 8 * WORDS;

    // Padding-only block: domain byte first, final bit in the last byte.
    localparam logic [c_W-1:0] c_PAD_BLK = {PAD_BYTE, {(c_W-16){1'b0}}, 8'h80};

    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_FULL = 2'd1,
        S_PAD  = 2'd2
    } state_t;

    state_t         r_state;
    logic [3:0]     r_k;
    logic           r_pend;
    logic [c_W-1:0] r_out;
    logic           r_out_valid;
    logic           r_out_last;
    logic           r_in_ready;

    logic           w_acc;
    logic [3:0]     w_m;
    logic [6:0]     w_p;
    logic           w_last_slot;
    logic [c_W-1:0] w_fill_blk;

    assign w_acc       = in_valid & r_in_ready;
    // Byte counts above 8 are treated as a full word.
    assign w_m         = (byte_num > 4'd8) ? 4'd8 : byte_num;
    // Position of the first byte after the message within the block.
    assign w_p         = {r_k, 3'b000} + {3'b000, w_m};
    assign w_last_slot = (r_k == 4'(WORDS - 1));

    // Next block contents when a word is accepted: write slot k, and for the
    // last word also clear the tail and drop in the pad byte and final bit.
    always_comb begin
        w_fill_blk = r_out;
        for (int j = 0; j < c_BYTES; j++) begin
            if ((j / 8) == int'(r_k)) begin
                if (!is_last || (j % 8) < int'(w_m)) begin
                    w_fill_blk[c_W-1-8*j -: 8] = in[63-8*(j%8) -: 8];
                end else begin
                    w_fill_blk[c_W-1-8*j -: 8] = 8'h00;
                end
            end else if (((j / 8) > int'(r_k)) && is_last) begin
                w_fill_blk[c_W-1-8*j -: 8] = 8'h00;
            end
            if (is_last && (j == int'(w_p))) begin
                w_fill_blk[c_W-1-8*j -: 8] = PAD_BYTE;
            end
        end
        // The final bit is OR-ed so a pad byte landing on byte 71 merges.
        if (is_last && (w_p < 7'(c_BYTES))) begin
            w_fill_blk[7:0] = w_fill_blk[7:0] | 8'h80;
        end
    end

    // Control FSM: FILL collects words, FULL presents a block until acked,
    // PAD builds the extra padding-only block for exactly-full messages.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_FILL;
            r_k         <= 4'd0;
            r_pend      <= 1'b0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                S_FILL: begin
                    if (w_acc) begin
                        r_out <= w_fill_blk;
                        r_k   <= r_k + 4'd1;
                        if (is_last) begin
                            r_state     <= S_FULL;
                            r_out_valid <= 1'b1;
                            r_in_ready  <= 1'b0;
                            if (w_p == 7'(c_BYTES)) begin
                                // No room for padding: a pad-only block follows.
                                r_out_last <= 1'b0;
                                r_pend     <= 1'b1;
                            end else begin
                                r_out_last <= 1'b1;
                                r_pend     <= 1'b0;
                            end
                        end else if (w_last_slot) begin
                            r_state     <= S_FULL;
                            r_out_valid <= 1'b1;
                            r_in_ready  <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_pend      <= 1'b0;
                        end
                    end
                end
                S_FULL: begin
                    if (f_ack) begin
                        r_out_valid <= 1'b0;
                        if (r_pend) begin
                            r_state <= S_PAD;
                        end else begin
                            r_state    <= S_FILL;
                            r_k        <= 4'd0;
                            r_in_ready <= 1'b1;
                            r_out_last <= 1'b0;
                        end
                    end
                end
                S_PAD: begin
                    r_out       <= c_PAD_BLK;
                    r_state     <= S_FULL;
                    r_out_valid <= 1'b1;
                    r_out_last  <= 1'b1;
                    r_pend      <= 1'b0;
                end
                default: begin
                    r_state     <= S_FILL;
                    r_k         <= 4'd0;
                    r_pend      <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_out_last  <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign in_ready  = r_in_ready;

`ifdef ABSORB576_BYTECNT_EN
    logic [15:0] r_msg_bytes;
    logic [15:0] w_add;
    logic [16:0] w_sum;

    assign w_add = is_last ? {12'd0, w_m} : 16'd8;
    assign w_sum = {1'b0, r_msg_bytes} + {1'b0, w_add};

    // Saturating message byte counter, cleared once the final block is taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_msg_bytes <= 16'd0;
        end else if ((r_state == S_FULL) && f_ack && r_out_last) begin
            r_msg_bytes <= 16'd0;
        end else if (w_acc) begin
            r_msg_bytes <= w_sum[16] ? 16'hFFFF : w_sum[15:0];
        end
    end

    assign msg_bytes = r_msg_bytes;
`endif

endmodule
`default_nettype wire

// File: tb/tb_absorb_ctrl_576.sv
`default_nettype none
// ============================================================================
//  Module   : tb_absorb_ctrl_576
//  Purpose  : Self-checking bench for absorb_ctrl_576: table of single-word
//             messages plus hand-written multi-cycle sequences (exact-fill
//             pad block, 71-byte message, backpressure, async reset, and the
//             byte counter when ABSORB576_BYTECNT_EN is defined).
//  Revision : 1.0  initial release
// ============================================================================
module tb_absorb_ctrl_576;

    logic         clk;
    logic         reset;
    logic [63:0]  in;
    logic         in_valid;
    logic         in_ready;
    logic         is_last;
    logic [3:0]   byte_num;
    logic [575:0] out;
    logic         out_valid;
    logic         out_last;
    logic         f_ack;
`ifdef ABSORB576_BYTECNT_EN
    logic [15:0]  msg_bytes;
`endif

    int errors = 0;
    int checks = 0;

    absorb_ctrl_576 dut (
        .clk       (clk),
        .reset     (reset),
        .in        (in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .is_last   (is_last),
        .byte_num  (byte_num),
        .out       (out),
        .out_valid (out_valid),
        .out_last  (out_last),
        .f_ack     (f_ack)
`ifdef ABSORB576_BYTECNT_EN
        ,
        .msg_bytes (msg_bytes)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] word;
        logic [3:0]  bn;
        logic [63:0] s0;
        logic [63:0] s1;
        logic [7:0]  b71;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [575:0] act, input logic [575:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [63:0] w, input logic last, input logic [3:0] bn);
        in       = w;
        in_valid = 1'b1;
        is_last  = last;
        byte_num = bn;
        tick();
        in_valid = 1'b0;
        is_last  = 1'b0;
        byte_num = 4'd0;
    endtask

    task automatic do_ack();
        f_ack = 1'b1;
        tick();
        f_ack = 1'b0;
    endtask

    logic [63:0]  W;
    logic [575:0] exp_a;
    logic [575:0] exp_b;
    logic [575:0] pad_blk;

    initial begin
        W       = 64'h0123456789ABCDEF;
        exp_a   = {64'h90ABCD0600000000, 504'd0, 8'h80};
        exp_b   = {64'h5566060000000000, 504'd0, 8'h80};
        pad_blk = {8'h06, 560'd0, 8'h80};

        vecs[0] = '{64'h90ABCDEF11111111, 4'd3,  64'h90ABCD0600000000, 64'h0, 8'h80};
        vecs[1] = '{64'h90ABCDEF11111111, 4'd0,  64'h0600000000000000, 64'h0, 8'h80};
        vecs[2] = '{64'h1122334455667788, 4'd7,  64'h1122334455667706, 64'h0, 8'h80};
        vecs[3] = '{64'h0123456789ABCDEF, 4'd8,  64'h0123456789ABCDEF, 64'h0600000000000000, 8'h80};
        vecs[4] = '{64'h0123456789ABCDEF, 4'd15, 64'h0123456789ABCDEF, 64'h0600000000000000, 8'h80};
        vecs[5] = '{64'hAABBCCDDEEFF0011, 4'd1,  64'hAA06000000000000, 64'h0, 8'h80};

        reset    = 1'b1;
        in       = 64'd0;
        in_valid = 1'b0;
        is_last  = 1'b0;
        byte_num = 4'd0;
        f_ack    = 1'b0;
        tick();
        tick();
        chk("rst_out_valid", 576'(out_valid), 576'd0);
        chk("rst_out_last",  576'(out_last),  576'd0);
        chk("rst_in_ready",  576'(in_ready),  576'd1);
        chk("rst_out",       out,             576'd0);
        reset = 1'b0;
        tick();

        // Table: single-word messages of varying length.
        for (int i = 0; i < 6; i++) begin
            send_word(vecs[i].word, 1'b1, vecs[i].bn);
            chk($sformatf("v%0d_valid", i), 576'(out_valid), 576'd1);
            chk($sformatf("v%0d_last",  i), 576'(out_last),  576'd1);
            chk($sformatf("v%0d_ready", i), 576'(in_ready),  576'd0);
            chk($sformatf("v%0d_out",   i), out, {vecs[i].s0, vecs[i].s1, 440'd0, vecs[i].b71});
            do_ack();
            chk($sformatf("v%0d_ack_valid", i), 576'(out_valid), 576'd0);
            chk($sformatf("v%0d_ack_ready", i), 576'(in_ready),  576'd1);
        end

        // Exactly 72 bytes: full block, then padding-only block.
        for (int i = 0; i < 9; i++) begin
            if (i == 8) chk("x72_pre_valid", 576'(out_valid), 576'd0);
            send_word(W, (i == 8), 4'd8);
        end
        chk("x72_valid", 576'(out_valid), 576'd1);
        chk("x72_last",  576'(out_last),  576'd0);
        chk("x72_out",   out, {9{W}});
        do_ack();
        chk("x72_gap_valid", 576'(out_valid), 576'd0);
        chk("x72_gap_ready", 576'(in_ready),  576'd0);
        tick();
        chk("x72_pad_valid", 576'(out_valid), 576'd1);
        chk("x72_pad_last",  576'(out_last),  576'd1);
        chk("x72_pad_out",   out, pad_blk);
        do_ack();
        chk("x72_done_ready", 576'(in_ready), 576'd1);

        // 71-byte message: pad byte and final bit share byte 71.
        for (int i = 0; i < 9; i++) begin
            if (i < 8) send_word(W, 1'b0, 4'd0);
            else       send_word(64'hFEDCBA9876543210, 1'b1, 4'd7);
        end
        chk("x71_last", 576'(out_last), 576'd1);
        chk("x71_out",  out, {{8{W}}, 64'hFEDCBA9876543286});
        do_ack();

        // Backpressure: source holds a word while the block waits for ack.
        send_word(64'h90ABCDEF11111111, 1'b1, 4'd3);
        in       = 64'h5566778899AABBCC;
        in_valid = 1'b1;
        is_last  = 1'b1;
        byte_num = 4'd2;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk($sformatf("bp%0d_ready", c), 576'(in_ready), 576'd0);
            chk($sformatf("bp%0d_out",   c), out, exp_a);
        end
        f_ack = 1'b1;
        tick();
        f_ack = 1'b0;
        chk("bp_fill_ready", 576'(in_ready),  576'd1);
        chk("bp_fill_valid", 576'(out_valid), 576'd0);
        tick();
        in_valid = 1'b0;
        is_last  = 1'b0;
        chk("bp_next_valid", 576'(out_valid), 576'd1);
        chk("bp_next_out",   out, exp_b);
        do_ack();

        // Asynchronous reset in the middle of a block.
        for (int i = 0; i < 4; i++) send_word(W, 1'b0, 4'd0);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_valid", 576'(out_valid), 576'd0);
        chk("arst_ready", 576'(in_ready),  576'd1);
        chk("arst_out",   out, 576'd0);
        #1;
        reset = 1'b0;
        tick();
        send_word(64'h90ABCDEF11111111, 1'b1, 4'd3);
        chk("arst_msg_valid", 576'(out_valid), 576'd1);
        chk("arst_msg_out",   out, exp_a);
        do_ack();

`ifdef ABSORB576_BYTECNT_EN
        // Byte counter: 20 full words plus a 5-byte last word = 165 bytes.
        for (int i = 0; i < 20; i++) begin
            send_word(W, 1'b0, 4'd0);
            if (i == 8 || i == 17) do_ack();
        end
        send_word(W, 1'b1, 4'd5);
        chk("cnt_165", 576'(msg_bytes), 576'd165);
        do_ack();
        chk("cnt_clear", 576'(msg_bytes), 576'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
